// File: rtl/disp_scan_ctrl_if.sv
// Display controller bus: value/mask load side plus status and pin outputs.
// The controller takes the slave modport; the driver of values takes master.
interface disp_scan_ctrl_if;
    logic [31:0] value_i;
    logic [7:0]  dp_i;
    logic [7:0]  blank_i;
    logic        lz_en_i;
    logic        load_i;
    logic        pending_o;
    logic        frame_o;
    logic [7:0]  disp_an_o;
    logic [7:0]  disp_seg_o;

    modport master (
        output value_i,
        output dp_i,
        output blank_i,
        output lz_en_i,
        output load_i,
        input  pending_o,
        input  frame_o,
        input  disp_an_o,
        input  disp_seg_o
    );

    modport slave (
        input  value_i,
        input  dp_i,
        input  blank_i,
        input  lz_en_i,
        input  load_i,
        output pending_o,
        output frame_o,
        output disp_an_o,
        output disp_seg_o
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with frame-boundary
// double buffering of value, decimal points and blank masks.
module disp_scan_ctrl #(
    parameter int REFRESH_DIV = 100_000
) (
    input logic              clk_i,
    input logic              reset_i,
    disp_scan_ctrl_if.slave  bus
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  dp;
        logic [7:0]  blank;
    } frame_t;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          tick;
    logic          boundary;
    logic          pending;
    frame_t        shadow;
    frame_t        active;
    frame_t        incoming;
    logic [7:0]    supp;
    logic          lz_run;
    logic          dark;
    logic [7:0]    an_next;
    logic [7:0]    seg_next;
    logic [7:0]    disp_an;
    logic [7:0]    disp_seg;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        unique case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            4'hF: hex7 = 7'h0E;
        endcase
    endfunction

    assign tick     = (cnt == LAST);
    assign boundary = tick && (idx == 3'd7);
    assign incoming = {bus.value_i, bus.dp_i, bus.blank_i};

    // Suppression runs from digit 7 downward and stops at the first nonzero.
    always_comb begin
        supp   = '0;
        lz_run = bus.lz_en_i;
        for (int k = 7; k >= 1; k--) begin
            lz_run  = lz_run && (active.value[4*k +: 4] == 4'h0);
            supp[k] = lz_run;
        end
    end

    always_comb begin
        dark     = active.blank[idx] | supp[idx];
        an_next  = 8'hFF;
        seg_next = 8'hFF;
        if (!dark) begin
            an_next  = ~(8'h01 << idx);
            seg_next = {~active.dp[idx],
                        hex7(active.value[{idx, 2'b00} +: 4])};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt      <= '0;
            idx      <= 3'd7;
            pending  <= 1'b0;
            shadow   <= '0;
            active   <= {32'h0, 8'h00, 8'hFF};
            disp_an  <= 8'hFF;
            disp_seg <= 8'hFF;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= idx + 3'd1;
            end
            // A load landing on the boundary bypasses the shadow stage.
            if (boundary && bus.load_i) begin
                active <= incoming;
            end else if (boundary && pending) begin
                active <= shadow;
            end
            if (bus.load_i) begin
                shadow <= incoming;
            end
            pending  <= boundary ? 1'b0 : (pending | bus.load_i);
            disp_an  <= an_next;
            disp_seg <= seg_next;
        end
    end

    assign bus.pending_o  = pending;
    assign bus.frame_o    = boundary;
    assign bus.disp_an_o  = disp_an;
    assign bus.disp_seg_o = disp_seg;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with REFRESH_DIV = 4.
// cyc 0 is the first cycle after reset release (cnt = 0, idx = 7).
module tb_disp_scan_ctrl;

    logic clk = 1'b0;
    logic reset_i;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [7:0] an_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                               8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] seg_basic [8] = '{8'h78, 8'h82, 8'h92, 8'h99,
                                  8'hB0, 8'hA4, 8'hF9, 8'hC0};

    always #5 clk = ~clk;

    disp_scan_ctrl_if bus ();

    disp_scan_ctrl #(.REFRESH_DIV(4)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        reset_i     = 1'b1;
        bus.load_i  = 1'b0;
        step();
        step();
        reset_i = 1'b0;
        cyc     = 0;
    endtask

    task automatic load(input logic [31:0] v, input logic [7:0] dp,
                        input logic [7:0] bl);
        bus.value_i = v;
        bus.dp_i    = dp;
        bus.blank_i = bl;
        bus.load_i  = 1'b1;
        step();
        bus.load_i  = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        step();
        step();
        checks++;
        if (bus.disp_an_o !== 8'hFF || bus.disp_seg_o !== 8'hFF ||
            bus.pending_o !== 1'b0 || bus.frame_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state an=%h seg=%h pend=%b frm=%b exp FF FF 0 0",
                     bus.disp_an_o, bus.disp_seg_o, bus.pending_o, bus.frame_o);
        end
        reset_i = 1'b0;
        cyc     = 0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (bus.disp_an_o !== 8'hFF || bus.disp_seg_o !== 8'hFF) begin
                errors++;
                $display("FAIL reset_dark cyc=%0d an=%h seg=%h exp FF FF",
                         cyc, bus.disp_an_o, bus.disp_seg_o);
            end
            checks++;
            if (bus.frame_o !== (cyc % 32 == 3)) begin
                errors++;
                $display("FAIL reset_frame cyc=%0d got=%b exp=%b",
                         cyc, bus.frame_o, (cyc % 32 == 3));
            end
            step();
        end
    endtask

    task automatic test_basic_scan();
        do_reset();
        bus.lz_en_i = 1'b0;
        load(32'h0123_4567, 8'h01, 8'h00);
        for (int c = 1; c <= 3; c++) begin
            wait_to(c);
            checks++;
            if (bus.pending_o !== 1'b1) begin
                errors++;
                $display("FAIL basic_pending cyc=%0d got=%b exp=1",
                         cyc, bus.pending_o);
            end
        end
        checks++;
        if (bus.frame_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_frame got=%b exp=1", bus.frame_o);
        end
        step();
        checks++;
        if (bus.pending_o !== 1'b0 || bus.disp_an_o !== 8'hFF) begin
            errors++;
            $display("FAIL basic_commit pend=%b an=%h exp 0 FF",
                     bus.pending_o, bus.disp_an_o);
        end
        for (int k = 0; k < 8; k++) begin
            wait_to(5 + 4 * k);
            checks++;
            if (bus.disp_an_o !== an_tab[k] || bus.disp_seg_o !== seg_basic[k]) begin
                errors++;
                $display("FAIL basic_digit%0d_first an=%h seg=%h exp %h %h",
                         k, bus.disp_an_o, bus.disp_seg_o, an_tab[k], seg_basic[k]);
            end
            wait_to(8 + 4 * k);
            checks++;
            if (bus.disp_an_o !== an_tab[k] || bus.disp_seg_o !== seg_basic[k]) begin
                errors++;
                $display("FAIL basic_digit%0d_last an=%h seg=%h exp %h %h",
                         k, bus.disp_an_o, bus.disp_seg_o, an_tab[k], seg_basic[k]);
            end
        end
    endtask

    task automatic test_tear_free();
        wait_to(49);
        load(32'h1111_1111, 8'h00, 8'h00);
        checks++;
        if (bus.pending_o !== 1'b1) begin
            errors++;
            $display("FAIL tear_pending got=%b exp=1", bus.pending_o);
        end
        load(32'hFFFF_FFFF, 8'h00, 8'h00);
        for (int k = 4; k < 8; k++) begin
            wait_to(37 + 4 * k);
            checks++;
            if (bus.disp_an_o !== an_tab[k] || bus.disp_seg_o !== seg_basic[k]) begin
                errors++;
                $display("FAIL tear_old_digit%0d an=%h seg=%h exp %h %h",
                         k, bus.disp_an_o, bus.disp_seg_o, an_tab[k], seg_basic[k]);
            end
        end
        wait_to(67);
        checks++;
        if (bus.frame_o !== 1'b1 || bus.pending_o !== 1'b1) begin
            errors++;
            $display("FAIL tear_boundary frm=%b pend=%b exp 1 1",
                     bus.frame_o, bus.pending_o);
        end
        step();
        checks++;
        if (bus.pending_o !== 1'b0 || bus.disp_an_o !== 8'h7F ||
            bus.disp_seg_o !== 8'hC0) begin
            errors++;
            $display("FAIL tear_edge pend=%b an=%h seg=%h exp 0 7F C0",
                     bus.pending_o, bus.disp_an_o, bus.disp_seg_o);
        end
        for (int k = 0; k < 8; k++) begin
            wait_to(69 + 4 * k);
            checks++;
            if (bus.disp_an_o !== an_tab[k] || bus.disp_seg_o !== 8'h8E) begin
                errors++;
                $display("FAIL tear_new_digit%0d an=%h seg=%h exp %h 8E",
                         k, bus.disp_an_o, bus.disp_seg_o, an_tab[k]);
            end
        end
    endtask

    task automatic test_collision();
        wait_to(99);
        checks++;
        if (bus.frame_o !== 1'b1 || bus.pending_o !== 1'b0) begin
            errors++;
            $display("FAIL coll_boundary frm=%b pend=%b exp 1 0",
                     bus.frame_o, bus.pending_o);
        end
        load(32'h1234_5672, 8'h00, 8'h00);
        checks++;
        if (bus.pending_o !== 1'b0 || bus.disp_an_o !== 8'h7F ||
            bus.disp_seg_o !== 8'h8E) begin
            errors++;
            $display("FAIL coll_next pend=%b an=%h seg=%h exp 0 7F 8E",
                     bus.pending_o, bus.disp_an_o, bus.disp_seg_o);
        end
        step();
        checks++;
        if (bus.pending_o !== 1'b0 || bus.disp_an_o !== 8'hFE ||
            bus.disp_seg_o !== 8'hA4) begin
            errors++;
            $display("FAIL coll_digit0 pend=%b an=%h seg=%h exp 0 FE A4",
                     bus.pending_o, bus.disp_an_o, bus.disp_seg_o);
        end
        wait_to(105);
        checks++;
        if (bus.pending_o !== 1'b0 || bus.disp_an_o !== 8'hFD ||
            bus.disp_seg_o !== 8'hF8) begin
            errors++;
            $display("FAIL coll_digit1 pend=%b an=%h seg=%h exp 0 FD F8",
                     bus.pending_o, bus.disp_an_o, bus.disp_seg_o);
        end
    endtask

    task automatic test_lzs();
        do_reset();
        bus.lz_en_i = 1'b1;
        load(32'h0000_00A0, 8'h00, 8'h00);
        wait_to(5);
        checks++;
        if (bus.disp_an_o !== 8'hFE || bus.disp_seg_o !== 8'hC0) begin
            errors++;
            $display("FAIL lzs_digit0 an=%h seg=%h exp FE C0",
                     bus.disp_an_o, bus.disp_seg_o);
        end
        wait_to(9);
        checks++;
        if (bus.disp_an_o !== 8'hFD || bus.disp_seg_o !== 8'h88) begin
            errors++;
            $display("FAIL lzs_digit1 an=%h seg=%h exp FD 88",
                     bus.disp_an_o, bus.disp_seg_o);
        end
        for (int k = 2; k < 8; k++) begin
            wait_to(5 + 4 * k);
            checks++;
            if (bus.disp_an_o !== 8'hFF || bus.disp_seg_o !== 8'hFF) begin
                errors++;
                $display("FAIL lzs_dark_digit%0d an=%h seg=%h exp FF FF",
                         k, bus.disp_an_o, bus.disp_seg_o);
            end
        end
        wait_to(34);
        load(32'h0000_0000, 8'h00, 8'h00);
        checks++;
        if (bus.pending_o !== 1'b1 || bus.frame_o !== 1'b1) begin
            errors++;
            $display("FAIL lzs_zero_load pend=%b frm=%b exp 1 1",
                     bus.pending_o, bus.frame_o);
        end
        wait_to(37);
        checks++;
        if (bus.disp_an_o !== 8'hFE || bus.disp_seg_o !== 8'hC0) begin
            errors++;
            $display("FAIL lzs_zero_digit0 an=%h seg=%h exp FE C0",
                     bus.disp_an_o, bus.disp_seg_o);
        end
        for (int k = 1; k < 8; k++) begin
            wait_to(37 + 4 * k);
            checks++;
            if (bus.disp_an_o !== 8'hFF || bus.disp_seg_o !== 8'hFF) begin
                errors++;
                $display("FAIL lzs_zero_dark%0d an=%h seg=%h exp FF FF",
                         k, bus.disp_an_o, bus.disp_seg_o);
            end
        end
        wait_to(67);
        bus.lz_en_i = 1'b0;
        wait_to(73);
        checks++;
        if (bus.disp_an_o !== 8'hFD || bus.disp_seg_o !== 8'hC0) begin
            errors++;
            $display("FAIL lzs_live_off an=%h seg=%h exp FD C0",
                     bus.disp_an_o, bus.disp_seg_o);
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        wait_to(9);
        load(32'h1234_5678, 8'hFF, 8'h00);
        checks++;
        if (bus.pending_o !== 1'b1) begin
            errors++;
            $display("FAIL rstp_pending got=%b exp=1", bus.pending_o);
        end
        step();
        reset_i     = 1'b1;
        bus.value_i = 32'h8765_4321;
        bus.blank_i = 8'h00;
        bus.load_i  = 1'b1;
        step();
        reset_i    = 1'b0;
        bus.load_i = 1'b0;
        cyc        = 0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (bus.pending_o !== 1'b0 || bus.disp_an_o !== 8'hFF ||
                bus.disp_seg_o !== 8'hFF) begin
                errors++;
                $display("FAIL rstp_dark cyc=%0d pend=%b an=%h seg=%h exp 0 FF FF",
                         cyc, bus.pending_o, bus.disp_an_o, bus.disp_seg_o);
            end
            step();
        end
    endtask

    initial begin
        reset_i     = 1'b1;
        bus.value_i = '0;
        bus.dp_i    = '0;
        bus.blank_i = '0;
        bus.lz_en_i = 1'b0;
        bus.load_i  = 1'b0;
        test_reset();
        test_basic_scan();
        test_tear_free();
        test_collision();
        test_lzs();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d exp finish before timeout", cyc);
        $fatal(1, "timeout");
    end

endmodule
